// File: rtl/bcd_seq_add_ctrl.sv
// bcd_seq_add_ctrl: adds two packed multi-digit BCD operands by reusing one
// single-digit BCD adder, one digit per clock, least-significant digit first.
// Optional feature macro: BCD_SUB_EN (adds op_sub for nines-complement subtract).
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready operand handshake (a_in, b_in, c_in [, op_sub])
//   a_in, b_in        packed BCD operands, digit 0 in [3:0]
//   c_in              decimal carry-in to digit 0
//   out_valid/out_ready result handshake
//   sum_out, c_out    packed BCD result and carry out of the top digit
//   digit_err         some input digit of this operation exceeded 9
//   busy              high while digits are being processed
module bcd_seq_add_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned IDXW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a_in,
  input  logic [4*DIGITS-1:0]   b_in,
  input  logic                  c_in,
`ifdef BCD_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum_out,
  output logic                  c_out,
  output logic                  digit_err,
  output logic                  busy
);

  localparam int unsigned OPW   = 4 * DIGITS;
  localparam int unsigned SLOTS = 2 ** IDXW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [OPW-1:0]    a_q, a_n;
  logic [OPW-1:0]    b_q, b_n;
  logic              carry_q, carry_n;
  logic              sub_q, sub_n;
  logic [IDXW-1:0]   idx_q, idx_n;
  logic [OPW-1:0]    sum_n;
  logic              c_out_n;
  logic              digit_err_n;
  logic              in_ready_n;
  logic              out_valid_n;
  logic              busy_n;

  // Digit views sized to the full index range so idx selects without width games;
  // unused slots read as zero.
  logic [3:0] a_dig [SLOTS];
  logic [3:0] b_dig [SLOTS];

  always_comb begin : digit_unpack
    for (int i = 0; i < int'(SLOTS); i++) begin
      a_dig[i] = 4'd0;
      b_dig[i] = 4'd0;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      a_dig[i] = a_q[4*i +: 4];
      b_dig[i] = b_q[4*i +: 4];
    end
  end

  // Single-digit BCD adder stage on the currently indexed digit.
  logic [3:0] cur_a;
  logic [3:0] cur_b;
  logic [3:0] eff_b;
  logic [4:0] bin_sum;
  logic [3:0] dig_sum;
  logic       dig_carry;
  logic       dig_bad;

  always_comb begin : digit_adder
    cur_a   = a_dig[idx_q];
    cur_b   = b_dig[idx_q];
    // Subtraction uses the nines complement of B; wraps for invalid B digits.
    eff_b   = sub_q ? 4'(4'd9 - cur_b) : cur_b;
    bin_sum = 5'({1'b0, cur_a}) + 5'({1'b0, eff_b}) + 5'({4'd0, carry_q});
    if (bin_sum > 5'd9) begin
      dig_sum   = 4'(bin_sum[3:0] + 4'd6);
      dig_carry = 1'b1;
    end else begin
      dig_sum   = bin_sum[3:0];
      dig_carry = 1'b0;
    end
    // Error checks the original B digit, not the complemented one.
    dig_bad = (cur_a > 4'd9) || (cur_b > 4'd9);
  end

  // Next-state and next-register logic.
  always_comb begin : fsm_next
    state_n     = state_q;
    a_n         = a_q;
    b_n         = b_q;
    carry_n     = carry_q;
    sub_n       = sub_q;
    idx_n       = idx_q;
    sum_n       = sum_out;
    c_out_n     = c_out;
    digit_err_n = digit_err;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_n         = a_in;
          b_n         = b_in;
          idx_n       = '0;
          sum_n       = '0;
          digit_err_n = 1'b0;
`ifdef BCD_SUB_EN
          sub_n       = op_sub;
          carry_n     = op_sub ? 1'b1 : c_in;
`else
          sub_n       = 1'b0;
          carry_n     = c_in;
`endif
          state_n     = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (idx_q == IDXW'(i)) sum_n[4*i +: 4] = dig_sum;
        end
        carry_n = dig_carry;
        idx_n   = idx_q + IDXW'(1);
        if (dig_bad) digit_err_n = 1'b1;
        if (idx_q == IDXW'(DIGITS - 1)) begin
          c_out_n = dig_carry;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    busy_n      = (state_n == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      idx_q     <= '0;
      sum_out   <= '0;
      c_out     <= 1'b0;
      digit_err <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      carry_q   <= carry_n;
      sub_q     <= sub_n;
      idx_q     <= idx_n;
      sum_out   <= sum_n;
      c_out     <= c_out_n;
      digit_err <= digit_err_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Directed bench for bcd_seq_add_ctrl with DIGITS=4.
module tb_bcd_seq_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        c_in;
`ifdef BCD_SUB_EN
  logic        op_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_out;
  logic        c_out;
  logic        digit_err;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;
  int lat;
  int seen;

  bcd_seq_add_ctrl #(.DIGITS(4), .IDXW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
`ifdef BCD_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .c_out     (c_out),
    .digit_err (digit_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present operands and wait for the accepting edge; returns #1 after it.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub);
    @(negedge clk);
    a_in = a; b_in = b; c_in = cin; in_valid = 1'b1;
`ifdef BCD_SUB_EN
    op_sub = sub;
`endif
    if (sub) ; // sub only drives a port in the subtract build
    @(posedge clk); #1;
    // Scramble inputs: the controller must already hold its own copies.
    in_valid = 1'b0; a_in = 16'hFFFF; b_in = 16'hFFFF; c_in = ~cin;
`ifdef BCD_SUB_EN
    op_sub = ~sub;
`endif
  endtask

  // Count edges from acceptance until out_valid, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_out_valid", 32'(out_valid), 32'd0);
    check("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0; out_ready = 1'b0;
`ifdef BCD_SUB_EN
    op_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset / idle state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum_out), 32'h0000);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digit_err", 32'(digit_err), 32'd0);

    // 1234 + 8766 = 1_0000
    accept_op(16'h1234, 16'h8766, 1'b0, 1'b0);
    check("op1_busy", 32'(busy), 32'd1);
    check("op1_in_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    check("op1_latency", 32'(lat), 32'd4);
    check("op1_sum", 32'(sum_out), 32'h0000);
    check("op1_c_out", 32'(c_out), 32'd1);
    check("op1_digit_err", 32'(digit_err), 32'd0);
    check("op1_busy_done", 32'(busy), 32'd0);
    consume();

    // 0456 + 0123 + 1 = 0580, then back-pressure
    accept_op(16'h0456, 16'h0123, 1'b1, 1'b0);
    wait_done(lat);
    check("op2_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("op2_hold_valid", 32'(out_valid), 32'd1);
      check("op2_hold_sum", 32'(sum_out), 32'h0580);
      check("op2_hold_c_out", 32'(c_out), 32'd0);
      check("op2_hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;  // ignored while a result is pending
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    consume();

    // Invalid digit A sets the sticky error
    accept_op(16'h00A1, 16'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("op3_latency", 32'(lat), 32'd4);
    check("op3_digit_err", 32'(digit_err), 32'd1);
    consume();

    // Error clears on the next operation
    accept_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("op4_digit_err", 32'(digit_err), 32'd0);
    check("op4_sum", 32'(sum_out), 32'h0002);
    check("op4_c_out", 32'(c_out), 32'd0);
    consume();

    // Carry ripples through every digit: 9999 + 0001 with c_in=0
    accept_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done(lat);
    check("op5_sum", 32'(sum_out), 32'h0000);
    check("op5_c_out", 32'(c_out), 32'd1);
    consume();

    // Reset in the second RUN cycle discards the operation
    accept_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rr_in_ready", 32'(in_ready), 32'd1);
    check("rr_out_valid", 32'(out_valid), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_sum", 32'(sum_out), 32'h0000);
    check("rr_c_out", 32'(c_out), 32'd0);
    check("rr_digit_err", 32'(digit_err), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rr_no_valid", 32'(seen), 32'd0);

    // Back-to-back after reset still works
    accept_op(16'h0050, 16'h0050, 1'b0, 1'b0);
    wait_done(lat);
    check("op6_latency", 32'(lat), 32'd4);
    check("op6_sum", 32'(sum_out), 32'h0100);
    consume();

`ifdef BCD_SUB_EN
    accept_op(16'h0500, 16'h0123, 1'b0, 1'b1);
    wait_done(lat);
    check("sub1_sum", 32'(sum_out), 32'h0377);
    check("sub1_c_out", 32'(c_out), 32'd1);
    consume();

    accept_op(16'h0123, 16'h0500, 1'b1, 1'b1);
    wait_done(lat);
    check("sub2_sum", 32'(sum_out), 32'h9623);
    check("sub2_c_out", 32'(c_out), 32'd0);
    consume();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
